// File: rtl/conv_stream_ctrl.sv
// ---------------------------------------------------------------------------
// conv_stream_ctrl
// ---------------------------------------------------------------------------
// Control sequencer for a strided (stride == KERNEL_DIM) convolution engine.
// A frame starts with a weight load of WLEN bytes. Then, for each output row,
// one band of KERNEL_DIM image lines (BAND bytes) streams into the band
// buffer, and OUT_DIM results are emitted, one per output column. The
// datapath itself lives outside this block. This block only produces
// addresses, write strobes and handshakes.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_start, i_abort          begin a frame / cancel the running frame
//   i_w_valid, o_w_ready      weight byte handshake
//   o_w_we, o_w_addr          weight store write strobe and index
//   i_src_valid, o_src_ready  pixel byte handshake
//   o_buf_we, o_buf_addr      band buffer write strobe and address
//   o_blk_addr                output column (datapath window select)
//   o_res_valid, i_res_ready  result handshake
//   o_res_row                 output row of the current result
//   o_busy, o_done            frame active / one-cycle frame-complete pulse
// ---------------------------------------------------------------------------
module conv_stream_ctrl #(
    parameter int IMG_DIM    = 4,
    parameter int IMG_CH     = 3,
    parameter int KERNEL_DIM = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_w_valid,
    output logic       o_w_ready,
    output logic       o_w_we,
    output logic [7:0] o_w_addr,
    input  logic       i_src_valid,
    output logic       o_src_ready,
    output logic       o_buf_we,
    output logic [7:0] o_buf_addr,
    output logic [7:0] o_blk_addr,
    output logic       o_res_valid,
    input  logic       i_res_ready,
    output logic [7:0] o_res_row,
    output logic       o_busy,
    output logic       o_done
);

    localparam int OUT_DIM = IMG_DIM / KERNEL_DIM;
    localparam int BAND    = IMG_DIM * IMG_CH * KERNEL_DIM;
    localparam int WLEN    = KERNEL_DIM * KERNEL_DIM * IMG_CH;

    localparam logic [7:0] WLEN_LAST = 8'(WLEN - 1);
    localparam logic [7:0] BAND_LAST = 8'(BAND - 1);
    localparam logic [7:0] OUT_LAST  = 8'(OUT_DIM - 1);

    // The counters are 8 bits wide. Any geometry that does not fit them, or
    // that does not tile evenly, is rejected when the design is elaborated.
    generate
        if ((IMG_DIM % KERNEL_DIM) != 0 || BAND > 256 || WLEN > 256) begin : g_badParams
            $error("conv_stream_ctrl: unsupported IMG_DIM/IMG_CH/KERNEL_DIM combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        EMIT,
        DONE
    } state_t;

    state_t     r_state;
    logic [7:0] r_wCnt;
    logic [7:0] r_bandCnt;
    logic [7:0] r_col;
    logic [7:0] r_row;

    state_t     w_nextState;
    logic [7:0] w_nextWCnt;
    logic [7:0] w_nextBandCnt;
    logic [7:0] w_nextCol;
    logic [7:0] w_nextRow;
    logic       w_wReady;
    logic       w_srcReady;
    logic       w_resValid;
    logic       w_done;

    // State and counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_wCnt    <= '0;
            r_bandCnt <= '0;
            r_col     <= '0;
            r_row     <= '0;
        end else begin
            r_state   <= w_nextState;
            r_wCnt    <= w_nextWCnt;
            r_bandCnt <= w_nextBandCnt;
            r_col     <= w_nextCol;
            r_row     <= w_nextRow;
        end
    end

    // Next-state and counter logic. Each counter wraps to zero on its
    // terminal transfer, so every counter reads 0 whenever the block is
    // idle. Abort takes effect last, so it overrides anything the current
    // state would otherwise do.
    always_comb begin
        w_nextState   = r_state;
        w_nextWCnt    = r_wCnt;
        w_nextBandCnt = r_bandCnt;
        w_nextCol     = r_col;
        w_nextRow     = r_row;
        w_wReady      = 1'b0;
        w_srcReady    = 1'b0;
        w_resValid    = 1'b0;
        w_done        = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_start && !i_abort) begin
                    w_nextState   = LOAD_W;
                    w_nextWCnt    = '0;
                    w_nextBandCnt = '0;
                    w_nextCol     = '0;
                    w_nextRow     = '0;
                end
            end
            LOAD_W: begin
                w_wReady = 1'b1;
                if (i_w_valid) begin
                    if (r_wCnt == WLEN_LAST) begin
                        w_nextWCnt  = '0;
                        w_nextState = STREAM;
                    end else begin
                        w_nextWCnt = r_wCnt + 8'd1;
                    end
                end
            end
            STREAM: begin
                w_srcReady = 1'b1;
                if (i_src_valid) begin
                    if (r_bandCnt == BAND_LAST) begin
                        w_nextBandCnt = '0;
                        w_nextState   = EMIT;
                    end else begin
                        w_nextBandCnt = r_bandCnt + 8'd1;
                    end
                end
            end
            EMIT: begin
                // src_ready stays low here, so the band cannot be
                // overwritten while the datapath is still reading it.
                w_resValid = 1'b1;
                if (i_res_ready) begin
                    if (r_col < OUT_LAST) begin
                        w_nextCol = r_col + 8'd1;
                    end else begin
                        w_nextCol = '0;
                        if (r_row < OUT_LAST) begin
                            w_nextRow   = r_row + 8'd1;
                            w_nextState = STREAM;
                        end else begin
                            w_nextRow   = '0;
                            w_nextState = DONE;
                        end
                    end
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        if (i_abort && r_state != IDLE) begin
            w_nextState   = IDLE;
            w_nextWCnt    = '0;
            w_nextBandCnt = '0;
            w_nextCol     = '0;
            w_nextRow     = '0;
        end
    end

    // The write strobes and the done pulse are masked by abort. A cancelled
    // frame therefore never commits a byte and never reports completion.
    assign o_w_ready   = w_wReady;
    assign o_w_we      = w_wReady && i_w_valid && !i_abort;
    assign o_w_addr    = r_wCnt;
    assign o_src_ready = w_srcReady;
    assign o_buf_we    = w_srcReady && i_src_valid && !i_abort;
    assign o_buf_addr  = r_bandCnt;
    assign o_blk_addr  = r_col;
    assign o_res_valid = w_resValid;
    assign o_res_row   = r_row;
    assign o_busy      = (r_state != IDLE);
    assign o_done      = w_done && !i_abort;

endmodule

// File: doc/conv_stream_ctrl.md
CONV_STREAM_CTRL -- requirements
Module: conv_stream_ctrl

Interface
REQ-001 Parameter: IMG_DIM, 4, square input image side in pixels.
REQ-002 Parameter: IMG_CH, 3, channels per pixel, innermost in stream order.
REQ-003 Parameter: KERNEL_DIM, 2, square kernel side; stride equals KERNEL_DIM.
REQ-004 Derived constants: OUT_DIM = IMG_DIM/KERNEL_DIM; BAND = IMG_DIM*IMG_CH*KERNEL_DIM; WLEN = KERNEL_DIM*KERNEL_DIM*IMG_CH.
REQ-005 Elaboration SHALL fail unless IMG_DIM % KERNEL_DIM == 0, BAND <= 256 and WLEN <= 256.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  begin one frame (weights, then image).
REQ-009 abort  in  1  cancel current frame.
REQ-010 w_valid / w_ready  in / out  1 / 1  weight byte handshake.
REQ-011 w_we, w_addr  out  1, 8  weight store write strobe and index 0..WLEN-1.
REQ-012 src_valid / src_ready  in / out  1 / 1  pixel byte handshake.
REQ-013 buf_we, buf_addr  out  1, 8  band buffer write strobe and address 0..BAND-1.
REQ-014 blk_addr  out  8  output column selecting datapath window 0..OUT_DIM-1.
REQ-015 res_valid / res_ready  out / in  1 / 1  convolution result handshake.
REQ-016 res_row  out  8  output row of the current result.
REQ-017 busy, done  out  1, 1  frame active; one-cycle frame-complete pulse.

Function
REQ-018 FSM states: IDLE, LOAD_W, STREAM, EMIT, DONE; reset state is IDLE.
REQ-019 IDLE: start=1 -> LOAD_W with w_cnt, band_cnt, col and row cleared; start is ignored in every other state.
REQ-020 LOAD_W: w_ready=1; a transfer is w_valid&&w_ready; w_we = transfer (combinational); w_addr = w_cnt; the transfer of index WLEN-1 -> STREAM.
REQ-021 STREAM: src_ready=1; buf_we = src_valid&&src_ready; buf_addr = band_cnt; band_cnt increments per transfer; the transfer at band_cnt==BAND-1 wraps band_cnt to 0 -> EMIT.
REQ-022 EMIT: src_ready=0, so the band buffer is never overwritten; res_valid=1; blk_addr = col; res_row = row.
REQ-023 EMIT: res_valid SHALL first assert the cycle after the last band byte is accepted (1-cycle latency), and SHALL hold stable with unchanged blk_addr/res_row until res_ready=1.
REQ-024 EMIT with res_ready=1: if col < OUT_DIM-1, col increments; otherwise col clears and, if row < OUT_DIM-1, row increments -> STREAM, else -> DONE.
REQ-025 DONE: done=1 for exactly one cycle -> IDLE.
REQ-026 busy=1 in every state except IDLE.
REQ-027 w_ready, src_ready and res_valid SHALL be 0 outside LOAD_W, STREAM and EMIT respectively; w_we and buf_we SHALL never assert without the matching handshake.
REQ-028 abort=1 in any non-IDLE state -> IDLE next cycle; all counters clear; no done pulse; strobes deassert that cycle.
REQ-029 abort and start asserted together in IDLE: abort wins, and the block stays IDLE.
REQ-030 All counters are 8 bits and never exceed their terminal value; the frame yields exactly OUT_DIM*OUT_DIM results in row-major order.

Reset
REQ-031 rst=1 -> next edge: state IDLE; counters 0; busy, done, w_ready, src_ready, res_valid, w_we and buf_we 0; w_addr, buf_addr, blk_addr and res_row 0.
REQ-032 rst has priority over start and abort; rst mid-frame discards the frame with no done pulse.

Verification
REQ-033 Defaults, start pulse, 12 weights back-to-back, 24 pixels, res_ready=1 -> w_addr 0..11, buf_addr 0..23, res_valid on the cycle after pixel 23 with blk_addr 0 then 1 and res_row 0.
REQ-034 Full frame with res_ready=1 -> exactly 4 results (row,col) = (0,0),(0,1),(1,0),(1,1); done pulses once; busy then falls.
REQ-035 res_ready held 0 for 3 cycles in EMIT -> res_valid and blk_addr stay stable; src_ready stays 0; src_valid=1 produces no buf_we.
REQ-036 src_valid toggled randomly during STREAM -> buf_addr advances only on handshake cycles; the band still wraps at 23 -> 0.
REQ-037 abort after pixel 10 of band 1 -> IDLE next cycle with all outputs 0 and no done; a new start then runs a clean frame identical to REQ-034.
REQ-038 start asserted during STREAM, and start+abort asserted together in IDLE -> both ignored; busy unaffected.
